// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART memory command path.
// Holds the opcode bytes, the command FSM state encoding and default bus widths.
// No ports; imported by uart_mem_cmd and its helpers.
package uart_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    IDLE,
    ADDR_W,
    ADDR_R,
    DATA,
    WR,
    RD,
    WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/cmd_timeout.sv
// Idle-gap counter: counts clocks while enabled, clears on clr, can be preloaded.
// Latency: expired is combinational from the count, so the owner reacts on the LIMIT-th idle edge.
// Backpressure: none; expired is a plain level, LIMIT=0 disables it entirely.
// Ports: clock/reset (sync, active-high), en (count while high, else hold at 0),
//        clr (restart from 0), load/load_val (preload), expired (this clock completes LIMIT idle cycles).
module cmd_timeout #(
  parameter int WIDTH = 20,
  parameter int LIMIT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  // Value held on the cycle whose closing edge makes the count equal LIMIT.
  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clr || !en || (LIMIT == 0)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && en && !clr && !load && (count == LAST);

endmodule

// File: rtl/uart_mem_cmd.sv
// Byte-stream command initiator: 'W' addr data writes memory, 'R' addr reads it back over tx.
// Latency: write strobe the cycle after the data byte; read strobe the cycle after the address byte,
//          tx_valid READ_LATENCY+1 cycles after the read strobe.
// Backpressure: tx_valid/tx_byte held until tx_ready; rx bytes arriving mid-execution are dropped
//               with a one-cycle overrun pulse.
// Ports: clock/reset (sync, active-high); rx_valid/rx_byte from the UART receiver;
//        tx_valid/tx_ready/tx_byte to the UART transmitter; mem_read/mem_write/mem_addr/mem_wdata/
//        mem_rdata to the memory; busy (not IDLE); overrun (dropped rx byte).
module uart_mem_cmd #(
  parameter int         ADDR_WIDTH     = uart_mem_pkg::DEF_ADDR_WIDTH,
  parameter int         DATA_WIDTH     = uart_mem_pkg::DEF_DATA_WIDTH,
  parameter int         READ_LATENCY   = 1,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] OP_WRITE       = uart_mem_pkg::OP_WRITE,
  parameter logic [7:0] OP_READ        = uart_mem_pkg::OP_READ
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  overrun
);

  import uart_mem_pkg::*;

  localparam int TO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       to_en;
  logic       to_expired;

  // The timeout only runs while a command is partially received. Every
  // accepted byte restarts it, and leaving these states clears it via en.
  assign to_en = (state == ADDR_W) || (state == ADDR_R) || (state == DATA);

  cmd_timeout #(
    .WIDTH (TO_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .en       (to_en),
    .clr      (rx_valid),
    .load     (1'b0),
    .load_val ('0),
    .expired  (to_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      // Strobes are single-cycle; each is raised only on entry to WR/RD.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      overrun   <= rx_valid && ((state == WR) || (state == RD) ||
                                (state == WAIT) || (state == SEND));

      case (state)
        IDLE: begin
          if (rx_valid && (rx_byte == OP_WRITE)) begin
            state <= ADDR_W;
            busy  <= 1'b1;
          end else if (rx_valid && (rx_byte == OP_READ)) begin
            state <= ADDR_R;
            busy  <= 1'b1;
          end
        end

        ADDR_W, ADDR_R: begin
          if (rx_valid) begin
            mem_addr <= rx_byte[ADDR_WIDTH-1:0];
            if (state == ADDR_W) begin
              state <= DATA;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
            end
          end else if (to_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        DATA: begin
          if (rx_valid) begin
            mem_wdata <= rx_byte[DATA_WIDTH-1:0];
            mem_write <= 1'b1;
            state     <= WR;
          end else if (to_expired) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        WR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        RD: begin
          state   <= WAIT;
          lat_cnt <= 3'(READ_LATENCY);
        end

        WAIT: begin
          // lat_cnt==1 marks the cycle in which mem_rdata is valid.
          if (lat_cnt == 3'd1) begin
            tx_byte  <= mem_rdata;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
          lat_cnt <= lat_cnt - 3'd1;
        end

        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_cmd.sv
module tb_uart_mem_cmd;

  logic       clock;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       overrun;

  int passed = 0;
  int total  = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;

  logic [7:0] mem [256];

  uart_mem_cmd #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (8),
    .READ_LATENCY   (1),
    .TIMEOUT_CYCLES (8),
    .OP_WRITE       (8'h57),
    .OP_READ        (8'h52)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: one-cycle read latency.
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  // Event counters sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (tx_valid && tx_ready) tx_cnt <= tx_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic wait_tx(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({tx_valid, mem_read, mem_write, busy, overrun} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b want 00000", {tx_valid, mem_read, mem_write, busy, overrun});
    end else passed++;
    total++;
    if ({tx_byte, mem_addr, mem_wdata} !== 24'h0) begin
      $display("FAIL reset_data: got %h want 000000", {tx_byte, mem_addr, mem_wdata});
    end else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    send_byte(8'h57);
    total++;
    if (busy !== 1'b1) $display("FAIL write_busy: got %b want 1", busy); else passed++;
    send_byte(8'h0A);
    send_byte(8'h07);
    total++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !== {2'b10, 8'h0A, 8'h07}) begin
      $display("FAIL write_strobe: got w=%b r=%b a=%h d=%h want w=1 r=0 a=0a d=07",
               mem_write, mem_read, mem_addr, mem_wdata);
    end else passed++;
    tick();
    total++;
    if ({mem_write, busy} !== 2'b00) $display("FAIL write_done: got w=%b busy=%b want 0 0", mem_write, busy);
    else passed++;
    total++;
    if (wr_cnt - w0 != 1) $display("FAIL write_count: got %0d want 1", wr_cnt - w0); else passed++;
  endtask

  task automatic test_readback();
    bit seen;
    tx_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h0A);
    total++;
    if ({mem_read, mem_write, mem_addr} !== {2'b10, 8'h0A}) begin
      $display("FAIL read_strobe: got r=%b w=%b a=%h want r=1 w=0 a=0a", mem_read, mem_write, mem_addr);
    end else passed++;
    tick();
    total++;
    if ({tx_valid, mem_read} !== 2'b00) $display("FAIL read_wait: got tv=%b r=%b want 0 0", tx_valid, mem_read);
    else passed++;
    wait_tx(seen);
    total++;
    if (!seen || tx_byte !== 8'h07) $display("FAIL read_data: got seen=%b byte=%h want 1 07", seen, tx_byte);
    else passed++;
  endtask

  task automatic test_backpressure();
    int t0;
    t0 = tx_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({tx_valid, tx_byte, busy} !== {1'b1, 8'h07, 1'b1}) begin
        $display("FAIL bp_hold[%0d]: got tv=%b byte=%h busy=%b want 1 07 1", i, tx_valid, tx_byte, busy);
      end else passed++;
    end
    tx_ready = 1'b1;
    tick();
    total++;
    if ({tx_valid, busy} !== 2'b00) $display("FAIL bp_release: got tv=%b busy=%b want 0 0", tx_valid, busy);
    else passed++;
    tick();
    total++;
    if (tx_cnt - t0 != 1) $display("FAIL bp_transfers: got %0d want 1", tx_cnt - t0); else passed++;
  endtask

  task automatic test_junk_and_timeout();
    int w0, r0, o0;
    bit seen;
    w0 = wr_cnt; r0 = rd_cnt; o0 = ov_cnt;
    send_byte(8'h41);
    tick();
    total++;
    if (busy !== 1'b0 || wr_cnt != w0 || rd_cnt != r0 || ov_cnt != o0) begin
      $display("FAIL junk: got busy=%b wr=%0d rd=%0d ov=%0d want 0 0 0 0", busy, wr_cnt - w0, rd_cnt - r0, ov_cnt - o0);
    end else passed++;
    send_byte(8'h57);
    send_byte(8'h0A);
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (busy !== 1'b1) $display("FAIL timeout_early: got busy=%b want 1", busy); else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b want 0", busy); else passed++;
    tick();
    total++;
    if (wr_cnt != w0) $display("FAIL timeout_nowrite: got %0d writes want 0", wr_cnt - w0); else passed++;
    tx_ready = 1'b1;
    send_byte(8'h52);
    send_byte(8'h0A);
    wait_tx(seen);
    total++;
    if (!seen || tx_byte !== 8'h07) $display("FAIL timeout_read: got seen=%b byte=%h want 1 07", seen, tx_byte);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_overrun();
    int o0, r0, w0;
    bit seen;
    tx_ready = 1'b0;
    r0 = rd_cnt; w0 = wr_cnt;
    send_byte(8'h52);
    send_byte(8'h0A);
    wait_tx(seen);
    o0 = ov_cnt;
    send_byte(8'h33);
    total++;
    if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", overrun); else passed++;
    tick();
    total++;
    if ({overrun, tx_valid, busy, tx_byte} !== {3'b011, 8'h07}) begin
      $display("FAIL overrun_hold: got ov=%b tv=%b busy=%b byte=%h want 0 1 1 07", overrun, tx_valid, busy, tx_byte);
    end else passed++;
    tx_ready = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || ov_cnt - o0 != 1 || rd_cnt - r0 != 1 || wr_cnt != w0) begin
      $display("FAIL overrun_counts: got busy=%b ov=%0d rd=%0d wr=%0d want 0 1 1 0",
               busy, ov_cnt - o0, rd_cnt - r0, wr_cnt - w0);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h0A);
    reset = 1'b1;
    tick();
    total++;
    if ({tx_valid, mem_read, mem_write, busy, overrun, tx_byte, mem_addr, mem_wdata} !== 29'h0) begin
      $display("FAIL midreset_outputs: got tv=%b r=%b w=%b busy=%b ov=%b tb=%h a=%h d=%h want all 0",
               tx_valid, mem_read, mem_write, busy, overrun, tx_byte, mem_addr, mem_wdata);
    end else passed++;
    reset = 1'b0;
    send_byte(8'h11);
    tick();
    total++;
    if (busy !== 1'b0 || wr_cnt != w0) $display("FAIL midreset_ignore: got busy=%b wr=%0d want 0 0", busy, wr_cnt - w0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    tx_ready = 1'b1;
    send_byte(8'h57);
    send_byte(8'h0B);
    send_byte(8'h5C);
    total++;
    if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 8'h0B, 8'h5C}) begin
      $display("FAIL b2b_write: got w=%b a=%h d=%h want 1 0b 5c", mem_write, mem_addr, mem_wdata);
    end else passed++;
    tick();
    send_byte(8'h52);
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy); else passed++;
    send_byte(8'h0B);
    wait_tx(seen);
    total++;
    if (!seen || tx_byte !== 8'h5C) $display("FAIL b2b_read: got seen=%b byte=%h want 1 5c", seen, tx_byte);
    else passed++;
    tick();
    tick();
    total++;
    if (both_cnt != 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", both_cnt); else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_ready = 1'b0;
    test_reset();
    test_write();
    test_readback();
    test_backpressure();
    test_junk_and_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
